// File: rtl/cipher_ctrl_fsm.sv
// cipher_ctrl_fsm
// Sequencer for the encode/decode datapath: after a start request it issues
// NUM_LOAD key-byte load strobes, KEY_ROUNDS key-generation strobes and
// CRYPT_ROUNDS encode or decode strobes, then a one-cycle done pulse.
// Strobes are gated by dp_stall; abort returns to IDLE without done.
module cipher_ctrl_fsm #(
  parameter int unsigned NUM_LOAD     = 2,
  parameter int unsigned KEY_ROUNDS   = 2,
  parameter int unsigned CRYPT_ROUNDS = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             enable,
  input  logic             encode,
  input  logic             dp_stall,
  input  logic             abort,
  output logic [2:0]       state,
  output logic             load_en,
  output logic             key_gen,
  output logic             outcode,
  output logic             crypt_mode,
  output logic [CNT_W-1:0] step_idx,
  output logic             busy,
  output logic             done
);

  // Number of distinct step indices the counter can hold.
  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  // Every phase length must be non-zero and reachable by the step counter.
  if (NUM_LOAD < 1 || NUM_LOAD > CNT_SPAN ||
      KEY_ROUNDS < 1 || KEY_ROUNDS > CNT_SPAN ||
      CRYPT_ROUNDS < 1 || CRYPT_ROUNDS > CNT_SPAN) begin : g_param_err
    $error("cipher_ctrl_fsm: phase counts must be in 1..2**CNT_W");
  end

  // Counter value on the final strobe of each phase.
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(NUM_LOAD - 1);
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CRYPT_LAST = CNT_W'(CRYPT_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD   = 3'b001,
    S_KEYGEN = 3'b010,
    S_ENCODE = 3'b011,
    S_DECODE = 3'b100,
    S_DONE   = 3'b101
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic             in_phase;
  logic             strobe;
  logic             phase_last;

  // Phase membership, strobe qualification and last-step detection.
  always_comb begin
    in_phase   = 1'b0;
    phase_last = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_phase   = 1'b1;
        phase_last = (cnt_q == LOAD_LAST);
      end
      S_KEYGEN: begin
        in_phase   = 1'b1;
        phase_last = (cnt_q == KEY_LAST);
      end
      S_ENCODE, S_DECODE: begin
        in_phase   = 1'b1;
        phase_last = (cnt_q == CRYPT_LAST);
      end
      default: begin
        in_phase   = 1'b0;
        phase_last = 1'b0;
      end
    endcase
    strobe = in_phase & ~dp_stall;
  end

  // Next-state, step counter and mode latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          mode_d  = encode;
        end
      end
      S_LOAD: begin
        if (strobe) begin
          if (phase_last) begin
            state_d = S_KEYGEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_KEYGEN: begin
        if (strobe) begin
          if (phase_last) begin
            state_d = mode_q ? S_ENCODE : S_DECODE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ENCODE, S_DECODE: begin
        if (strobe) begin
          if (phase_last) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort outranks stall and sequencing in every non-idle state.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Output decode from the state register and dp_stall.
  always_comb begin
    state      = state_q;
    load_en    = (state_q == S_LOAD) & ~dp_stall;
    key_gen    = (state_q == S_KEYGEN) & ~dp_stall;
    outcode    = ((state_q == S_ENCODE) | (state_q == S_DECODE)) & ~dp_stall;
    crypt_mode = mode_q;
    step_idx   = in_phase ? cnt_q : '0;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_cipher_ctrl_fsm.sv
// Scoreboard bench for cipher_ctrl_fsm: the stimulus process pushes the
// hand-computed expected outputs for each driven cycle; a monitor pops and
// compares them on the falling edge of that cycle.
module tb_cipher_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn_a, rn_b, en, enc, stall, ab;

  logic [2:0] st_a, st_b;
  logic       ld_a, kg_a, oc_a, md_a, bz_a, dn_a;
  logic       ld_b, kg_b, oc_b, md_b, bz_b, dn_b;
  logic [3:0] idx_a;
  logic [2:0] idx_b;

  cipher_ctrl_fsm u_dut_a (
    .clka(clk), .restart_n(rn_a), .enable(en), .encode(enc),
    .dp_stall(stall), .abort(ab), .state(st_a), .load_en(ld_a),
    .key_gen(kg_a), .outcode(oc_a), .crypt_mode(md_a), .step_idx(idx_a),
    .busy(bz_a), .done(dn_a)
  );

  cipher_ctrl_fsm #(
    .NUM_LOAD(4), .KEY_ROUNDS(3), .CRYPT_ROUNDS(5), .CNT_W(3)
  ) u_dut_b (
    .clka(clk), .restart_n(rn_b), .enable(en), .encode(enc),
    .dp_stall(stall), .abort(ab), .state(st_b), .load_en(ld_b),
    .key_gen(kg_b), .outcode(oc_b), .crypt_mode(md_b), .step_idx(idx_b),
    .busy(bz_b), .done(dn_b)
  );

  // Expected vector layout: {state[2:0], load_en, key_gen, outcode,
  // crypt_mode, step_idx[3:0], busy, done}
  typedef struct {
    int         tst;
    int         cyc;
    logic [12:0] v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t        ea, eb;
  logic [12:0] oa, ob;

  function automatic logic [12:0] ev(input logic [2:0] s, input logic l, k, o, m,
                                     input int idx, input logic b, d);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {s, l, k, o, m, i4, b, d};
  endfunction

  task automatic drive(input logic a_rn, b_rn, e, m, s, a);
    @(posedge clk);
    #1;
    rn_a  = a_rn;
    rn_b  = b_rn;
    en    = e;
    enc   = m;
    stall = s;
    ab    = a;
  endtask

  // One cycle on DUT A (B held in reset), with its expected outputs.
  task automatic ca(input int t, c, input logic e, m, s, a, r, input logic [12:0] v);
    exp_t x;
    drive(r, 1'b0, e, m, s, a);
    x.tst = t; x.cyc = c; x.v = v;
    qa.push_back(x);
  endtask

  // One cycle on DUT B (A held in reset), with its expected outputs.
  task automatic cb(input int t, c, input logic e, m, s, a, r, input logic [12:0] v);
    exp_t x;
    drive(1'b0, r, e, m, s, a);
    x.tst = t; x.cyc = c; x.v = v;
    qb.push_back(x);
  endtask

  // Monitor: compare whatever is due this cycle, mid-cycle.
  always @(negedge clk) begin
    oa = {st_a, ld_a, kg_a, oc_a, md_a, idx_a, bz_a, dn_a};
    ob = {st_b, ld_b, kg_b, oc_b, md_b, 1'b0, idx_b, bz_b, dn_b};
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      n_cmp++;
      if (oa !== ea.v) begin
        n_bad++;
        $display("FAIL dutA t%0d c%0d: got %b required %b (st,ld,kg,oc,md,idx,bz,dn)",
                 ea.tst, ea.cyc, oa, ea.v);
      end
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      n_cmp++;
      if (ob !== eb.v) begin
        n_bad++;
        $display("FAIL dutB t%0d c%0d: got %b required %b (st,ld,kg,oc,md,idx,bz,dn)",
                 eb.tst, eb.cyc, ob, eb.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rn_a = 1'b0; rn_b = 1'b0; en = 1'b0; enc = 1'b0; stall = 1'b0; ab = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Reset state
    ca(0, 0, 0, 0, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));

    // Test 1: defaults, encode
    ca(1, 0, 1, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    ca(1, 1, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 0, 1, 0));
    ca(1, 2, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 1, 1, 0));
    ca(1, 3, 0, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 1, 0, 1, 0));
    ca(1, 4, 0, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 1, 1, 1, 0));
    ca(1, 5, 0, 1, 0, 0, 1, ev(3'd3, 0, 0, 1, 1, 0, 1, 0));
    ca(1, 6, 0, 1, 0, 0, 1, ev(3'd5, 0, 0, 0, 1, 0, 1, 1));
    ca(1, 7, 0, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));

    // Test 2: decode, encode toggled mid-operation
    ca(2, 0, 1, 0, 0, 0, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));
    ca(2, 1, 0, 0, 0, 0, 1, ev(3'd1, 1, 0, 0, 0, 0, 1, 0));
    ca(2, 2, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 0, 1, 1, 0));
    ca(2, 3, 0, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 0, 0, 1, 0));
    ca(2, 4, 0, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 0, 1, 1, 0));
    ca(2, 5, 0, 1, 0, 0, 1, ev(3'd4, 0, 0, 1, 0, 0, 1, 0));
    ca(2, 6, 0, 1, 0, 0, 1, ev(3'd5, 0, 0, 0, 0, 0, 1, 1));
    ca(2, 7, 0, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));

    // Test 3: stalls in cycles 2 and 4, stall also during DONE
    ca(3, 0, 1, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    ca(3, 1, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 0, 1, 0));
    ca(3, 2, 0, 1, 1, 0, 1, ev(3'd1, 0, 0, 0, 1, 1, 1, 0));
    ca(3, 3, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 1, 1, 0));
    ca(3, 4, 0, 1, 1, 0, 1, ev(3'd2, 0, 0, 0, 1, 0, 1, 0));
    ca(3, 5, 0, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 1, 0, 1, 0));
    ca(3, 6, 0, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 1, 1, 1, 0));
    ca(3, 7, 0, 1, 0, 0, 1, ev(3'd3, 0, 0, 1, 1, 0, 1, 0));
    ca(3, 8, 0, 1, 1, 0, 1, ev(3'd5, 0, 0, 0, 1, 0, 1, 1));
    ca(3, 9, 0, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));

    // Test 4: abort in KEY_GEN
    ca(4, 0, 1, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));
    ca(4, 1, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 0, 1, 0));
    ca(4, 2, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 1, 1, 0));
    ca(4, 3, 0, 1, 0, 1, 1, ev(3'd2, 0, 1, 0, 1, 0, 1, 0));
    ca(4, 4, 0, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));
    ca(4, 5, 0, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));

    // Test 7: abort+enable in IDLE starts; abort+enable in DONE returns to IDLE
    ca(7, 0, 1, 0, 0, 1, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));
    ca(7, 1, 0, 0, 0, 0, 1, ev(3'd1, 1, 0, 0, 0, 0, 1, 0));
    ca(7, 2, 0, 0, 0, 0, 1, ev(3'd1, 1, 0, 0, 0, 1, 1, 0));
    ca(7, 3, 0, 0, 0, 0, 1, ev(3'd2, 0, 1, 0, 0, 0, 1, 0));
    ca(7, 4, 0, 0, 0, 0, 1, ev(3'd2, 0, 1, 0, 0, 1, 1, 0));
    ca(7, 5, 0, 0, 0, 0, 1, ev(3'd4, 0, 0, 1, 0, 0, 1, 0));
    ca(7, 6, 1, 0, 0, 1, 1, ev(3'd5, 0, 0, 0, 0, 0, 1, 1));
    ca(7, 7, 0, 0, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    ca(7, 8, 0, 0, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));

    // Test 5: reset in KEY_GEN while stalled
    ca(5, 0, 1, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    ca(5, 1, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 0, 1, 0));
    ca(5, 2, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 1, 1, 0));
    ca(5, 3, 0, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 1, 0, 1, 0));
    ca(5, 4, 0, 1, 1, 0, 0, ev(3'd2, 0, 0, 0, 1, 1, 1, 0));
    ca(5, 5, 0, 1, 1, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    ca(5, 6, 0, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));

    // Test 6: 4/3/5 phases, CNT_W=3, enable held high
    cb(6, 0, 1, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) cb(6, 1 + i, 1, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, i, 1, 0));
    for (int i = 0; i < 3; i++) cb(6, 5 + i, 1, 1, 0, 0, 1, ev(3'd2, 0, 1, 0, 1, i, 1, 0));
    for (int i = 0; i < 5; i++) cb(6, 8 + i, 1, 1, 0, 0, 1, ev(3'd3, 0, 0, 1, 1, i, 1, 0));
    cb(6, 13, 1, 1, 0, 0, 1, ev(3'd5, 0, 0, 0, 1, 0, 1, 1));
    cb(6, 14, 1, 1, 0, 0, 1, ev(3'd0, 0, 0, 0, 1, 0, 0, 0));
    cb(6, 15, 1, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 0, 1, 0));
    cb(6, 16, 0, 1, 0, 0, 1, ev(3'd1, 1, 0, 0, 1, 1, 1, 0));

    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    n_cmp++;
    if ((qa.size() + qb.size()) != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, required 0",
               qa.size() + qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
